// File: rtl/onn_phase_loader_if.sv
// Serial-load side and committed-phase side of the ONN phase loader.
// The master drives the serial stream; the slave (the loader) returns the committed pattern and status.
interface onn_phase_loader_if #(
  parameter int N_OSC   = 15,
  parameter int PHASE_W = 4
);
  localparam int TOTAL = N_OSC * PHASE_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  logic             i_bit;
  logic             i_load;
  logic [TOTAL-1:0] o_phi_out;
  logic             o_phi_valid;
  logic             o_load_done;
  logic             o_frame_err;
  logic             o_overrun;
  logic             o_busy;
  logic [CNT_W-1:0] o_bit_cnt;

  modport master (
    output i_bit, i_load,
    input  o_phi_out, o_phi_valid, o_load_done, o_frame_err, o_overrun, o_busy, o_bit_cnt
  );

  modport slave (
    input  i_bit, i_load,
    output o_phi_out, o_phi_valid, o_load_done, o_frame_err, o_overrun, o_busy, o_bit_cnt
  );
endinterface

// File: rtl/onn_phase_loader.sv
// Serial phase-pattern loader: assembles N_OSC*PHASE_W bits in a shadow register and
// commits them to the oscillator phase bus only when a frame completes cleanly.
module onn_phase_loader #(
  parameter int N_OSC   = 15,
  parameter int PHASE_W = 4
) (
  input  logic               clk,
  input  logic               re_n,
  onn_phase_loader_if.slave  bus
);
  localparam int TOTAL = N_OSC * PHASE_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [TOTAL-1:0] r_shadow;
  logic [TOTAL-1:0] r_phi;
  logic             r_phi_valid;
  logic             r_load_done;
  logic             r_frame_err;
  logic             r_overrun;
  logic             r_busy;
  logic [CNT_W-1:0] r_bit_cnt;

  logic [TOTAL-1:0] w_shadow_next;
  logic [TOTAL-1:0] w_phi_next;
  logic             w_phi_valid_next;
  logic             w_load_done_next;
  logic             w_frame_err_next;
  logic             w_overrun_next;
  logic             w_busy_next;
  logic [CNT_W-1:0] w_bit_cnt_next;
  logic [TOTAL-1:0] w_shifted;

  // First received bit travels all the way up to the MSB (oscillator 0's MSB).
  generate
    if (TOTAL == 1) begin : g_single
      assign w_shifted = bus.i_bit;
    end else begin : g_multi
      assign w_shifted = {r_shadow[TOTAL-2:0], bus.i_bit};
    end
  endgenerate

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_load) begin
          w_state_next = (TOTAL == 1) ? S_FULL : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!bus.i_load) begin
          w_state_next = S_IDLE;
        end else if (r_bit_cnt == LAST_CNT) begin
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (!bus.i_load) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shadow_next    = r_shadow;
    w_phi_next       = r_phi;
    w_phi_valid_next = r_phi_valid;
    w_load_done_next = 1'b0;
    w_frame_err_next = 1'b0;
    w_overrun_next   = r_overrun;
    w_bit_cnt_next   = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.i_load) begin
          w_shadow_next  = w_shifted;
          w_bit_cnt_next = FIRST_CNT;
          if (TOTAL == 1) begin
            w_phi_next       = w_shifted;
            w_phi_valid_next = 1'b1;
            w_load_done_next = 1'b1;
            w_overrun_next   = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        if (bus.i_load) begin
          w_shadow_next  = w_shifted;
          w_bit_cnt_next = r_bit_cnt + FIRST_CNT;
          if (r_bit_cnt == LAST_CNT) begin
            w_phi_next       = w_shifted;
            w_phi_valid_next = 1'b1;
            w_load_done_next = 1'b1;
            w_overrun_next   = 1'b0;
          end
        end else begin
          // Short frame: drop the partial shadow so it can never leak into a later commit.
          w_frame_err_next = 1'b1;
          w_bit_cnt_next   = '0;
          w_shadow_next    = '0;
        end
      end
      S_FULL: begin
        if (bus.i_load) begin
          w_overrun_next = 1'b1;
        end else begin
          w_bit_cnt_next = '0;
          w_shadow_next  = '0;
        end
      end
      default: begin
        w_bit_cnt_next = '0;
        w_shadow_next  = '0;
      end
    endcase
    w_busy_next = (w_state_next == S_SHIFT);
  end

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      r_shadow    <= '0;
      r_phi       <= '0;
      r_phi_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_shadow    <= w_shadow_next;
      r_phi       <= w_phi_next;
      r_phi_valid <= w_phi_valid_next;
      r_load_done <= w_load_done_next;
      r_frame_err <= w_frame_err_next;
      r_overrun   <= w_overrun_next;
      r_busy      <= w_busy_next;
      r_bit_cnt   <= w_bit_cnt_next;
    end
  end

  assign bus.o_phi_out   = r_phi;
  assign bus.o_phi_valid = r_phi_valid;
  assign bus.o_load_done = r_load_done;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overrun   = r_overrun;
  assign bus.o_busy      = r_busy;
  assign bus.o_bit_cnt   = r_bit_cnt;
endmodule

// File: tb/tb_onn_phase_loader.sv
// Scoreboard bench for onn_phase_loader: default 15x4, a 4x3 and a 1x1 instance.
module tb_onn_phase_loader;
  logic clk = 1'b0;
  logic re_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen_a = 0;
  int err_exp_a  = 0;

  logic [59:0] q_a[$];
  logic [11:0] q_b[$];
  logic        q_c[$];
  logic [59:0] e_a;
  logic [11:0] e_b;
  logic        e_c;
  logic        prev_done_a = 1'b0;

  localparam logic [59:0] F1 = 60'h808C10010010288;
  localparam logic [59:0] F2 = 60'h123456789ABCDEF;
  localparam logic [59:0] F3 = 60'hFEDCBA987654321;
  localparam logic [59:0] F4 = 60'hA5A5A5A5A5A5A5A;
  localparam logic [59:0] F5 = 60'h0F0F0F0F0F0F0F0;

  onn_phase_loader_if #(.N_OSC(15), .PHASE_W(4)) if_a ();
  onn_phase_loader_if #(.N_OSC(4),  .PHASE_W(3)) if_b ();
  onn_phase_loader_if #(.N_OSC(1),  .PHASE_W(1)) if_c ();

  onn_phase_loader #(.N_OSC(15), .PHASE_W(4)) u_a (.clk(clk), .re_n(re_n), .bus(if_a.slave));
  onn_phase_loader #(.N_OSC(4),  .PHASE_W(3)) u_b (.clk(clk), .re_n(re_n), .bus(if_b.slave));
  onn_phase_loader #(.N_OSC(1),  .PHASE_W(1)) u_c (.clk(clk), .re_n(re_n), .bus(if_c.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic drv_a(input logic ld, input logic b);
    if_a.i_load = ld;
    if_a.i_bit  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_b(input logic ld, input logic b);
    if_b.i_load = ld;
    if_b.i_bit  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_c(input logic ld, input logic b);
    if_c.i_load = ld;
    if_c.i_bit  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_a(input logic [59:0] f);
    for (int i = 59; i >= 0; i--) drv_a(1'b1, f[i]);
  endtask

  // Scoreboard monitors: every commit pulse pops one expected frame.
  always @(negedge clk) begin
    if (if_a.o_load_done) begin
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a_commit: got unexpected commit phi=%h, expected no commit", if_a.o_phi_out);
      end else begin
        e_a = q_a.pop_front();
        if (if_a.o_phi_out !== e_a || if_a.o_phi_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_a_commit: got phi=%h valid=%b, expected phi=%h valid=1",
                   if_a.o_phi_out, if_a.o_phi_valid, e_a);
        end else begin
          $display("[TB] commit A phi=%h", if_a.o_phi_out);
        end
      end
      n_tests++;
      if (prev_done_a) begin
        n_fail++;
        $display("FAIL load_done_width: got 2+ cycles high, expected 1");
      end
    end
    if (if_a.o_frame_err) err_seen_a++;
    prev_done_a <= if_a.o_load_done;
  end

  always @(negedge clk) begin
    if (if_b.o_load_done) begin
      n_tests++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b_commit: got unexpected commit phi=%h, expected none", if_b.o_phi_out);
      end else begin
        e_b = q_b.pop_front();
        if (if_b.o_phi_out !== e_b) begin
          n_fail++;
          $display("FAIL sb_b_commit: got phi=%h, expected %h", if_b.o_phi_out, e_b);
        end else begin
          $display("[TB] commit B phi=%h", if_b.o_phi_out);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_c.o_load_done) begin
      n_tests++;
      if (q_c.size() == 0) begin
        n_fail++;
        $display("FAIL sb_c_commit: got unexpected commit phi=%b, expected none", if_c.o_phi_out);
      end else begin
        e_c = q_c.pop_front();
        if (if_c.o_phi_out !== e_c) begin
          n_fail++;
          $display("FAIL sb_c_commit: got phi=%b, expected %b", if_c.o_phi_out, e_c);
        end else begin
          $display("[TB] commit C phi=%b", if_c.o_phi_out);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    re_n = 1'b0;
    if_a.i_load = 1'b0; if_a.i_bit = 1'b0;
    if_b.i_load = 1'b0; if_b.i_bit = 1'b0;
    if_c.i_load = 1'b0; if_c.i_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phi_a",   64'(if_a.o_phi_out),   64'd0);
    chk("rst_valid_a", 64'(if_a.o_phi_valid), 64'd0);
    chk("rst_done_a",  64'(if_a.o_load_done), 64'd0);
    chk("rst_err_a",   64'(if_a.o_frame_err), 64'd0);
    chk("rst_ovr_a",   64'(if_a.o_overrun),   64'd0);
    chk("rst_busy_a",  64'(if_a.o_busy),      64'd0);
    chk("rst_cnt_a",   64'(if_a.o_bit_cnt),   64'd0);
    chk("rst_phi_b",   64'(if_b.o_phi_out),   64'd0);
    re_n = 1'b1;
    drv_a(1'b0, 1'b0);

    // Default frame
    q_a.push_back(F1);
    frame_a(F1);
    chk("f1_phi",   64'(if_a.o_phi_out),   64'(F1));
    chk("f1_valid", 64'(if_a.o_phi_valid), 64'd1);
    chk("f1_done",  64'(if_a.o_load_done), 64'd1);
    chk("f1_ovr",   64'(if_a.o_overrun),   64'd0);
    chk("f1_busy",  64'(if_a.o_busy),      64'd0);
    chk("f1_cnt",   64'(if_a.o_bit_cnt),   64'd60);
    drv_a(1'b0, 1'b0);
    chk("f1_done_off", 64'(if_a.o_load_done), 64'd0);
    chk("f1_cnt_clr",  64'(if_a.o_bit_cnt),   64'd0);

    // Short frame of 23 bits
    for (int i = 0; i < 23; i++) drv_a(1'b1, i[0]);
    chk("short_busy", 64'(if_a.o_busy),    64'd1);
    chk("short_cnt",  64'(if_a.o_bit_cnt), 64'd23);
    drv_a(1'b0, 1'b0);
    err_exp_a++;
    chk("short_err",   64'(if_a.o_frame_err), 64'd1);
    chk("short_cnt0",  64'(if_a.o_bit_cnt),   64'd0);
    chk("short_busy0", 64'(if_a.o_busy),      64'd0);
    chk("short_phi",   64'(if_a.o_phi_out),   64'(F1));
    chk("short_valid", 64'(if_a.o_phi_valid), 64'd1);
    drv_a(1'b0, 1'b0);
    chk("short_err_off", 64'(if_a.o_frame_err), 64'd0);

    // Overrun: 64 bits with load high
    q_a.push_back(F2);
    for (int i = 59; i >= 30; i--) drv_a(1'b1, F2[i]);
    chk("ovr_mid_phi", 64'(if_a.o_phi_out), 64'(F1));
    chk("ovr_mid_cnt", 64'(if_a.o_bit_cnt), 64'd30);
    for (int i = 29; i >= 0; i--) drv_a(1'b1, F2[i]);
    chk("ovr_commit_phi", 64'(if_a.o_phi_out), 64'(F2));
    chk("ovr_at60",       64'(if_a.o_overrun), 64'd0);
    drv_a(1'b1, 1'b1);
    chk("ovr_at61",     64'(if_a.o_overrun), 64'd1);
    chk("ovr_phi_kept", 64'(if_a.o_phi_out), 64'(F2));
    repeat (3) drv_a(1'b1, 1'b0);
    chk("ovr_cnt_sat", 64'(if_a.o_bit_cnt), 64'd60);
    chk("ovr_phi_end", 64'(if_a.o_phi_out), 64'(F2));
    drv_a(1'b0, 1'b0);
    chk("ovr_sticky", 64'(if_a.o_overrun), 64'd1);
    q_a.push_back(F3);
    frame_a(F3);
    chk("ovr_cleared", 64'(if_a.o_overrun), 64'd0);
    chk("f3_phi",      64'(if_a.o_phi_out), 64'(F3));
    drv_a(1'b0, 1'b0);

    // Back-to-back frames with one idle cycle
    q_a.push_back(F4);
    frame_a(F4);
    drv_a(1'b0, 1'b0);
    q_a.push_back(F5);
    frame_a(F5);
    drv_a(1'b0, 1'b0);
    chk("b2b_phi", 64'(if_a.o_phi_out), 64'(F5));

    // Reset mid-frame, asserted between clock edges
    for (int i = 59; i >= 30; i--) drv_a(1'b1, F1[i]);
    #2;
    re_n = 1'b0;
    if_a.i_load = 1'b0;
    #1;
    chk("arst_phi",   64'(if_a.o_phi_out),   64'd0);
    chk("arst_valid", 64'(if_a.o_phi_valid), 64'd0);
    chk("arst_busy",  64'(if_a.o_busy),      64'd0);
    chk("arst_cnt",   64'(if_a.o_bit_cnt),   64'd0);
    chk("arst_ovr",   64'(if_a.o_overrun),   64'd0);
    @(posedge clk);
    #1;
    re_n = 1'b1;
    q_a.push_back({60{1'b1}});
    frame_a({60{1'b1}});
    chk("ones_phi",   64'(if_a.o_phi_out),   64'({60{1'b1}}));
    chk("ones_valid", 64'(if_a.o_phi_valid), 64'd1);
    drv_a(1'b0, 1'b0);

    // 4x3 instance: 101 010 111 000
    q_b.push_back(12'hAB8);
    begin
      logic [11:0] fb;
      fb = 12'b101010111000;
      for (int i = 11; i >= 0; i--) drv_b(1'b1, fb[i]);
    end
    chk("b_phi",   64'(if_b.o_phi_out),   64'h0AB8);
    chk("b_valid", 64'(if_b.o_phi_valid), 64'd1);
    drv_b(1'b0, 1'b0);

    // 1x1 instance: single-bit frame commits on the first edge
    q_c.push_back(1'b1);
    drv_c(1'b1, 1'b1);
    chk("c_phi",  64'(if_c.o_phi_out),   64'd1);
    chk("c_done", 64'(if_c.o_load_done), 64'd1);
    chk("c_cnt",  64'(if_c.o_bit_cnt),   64'd1);
    chk("c_busy", 64'(if_c.o_busy),      64'd0);
    drv_c(1'b1, 1'b0);
    chk("c_ovr",     64'(if_c.o_overrun),   64'd1);
    chk("c_phi_kep", 64'(if_c.o_phi_out),   64'd1);
    drv_c(1'b0, 1'b0);
    chk("c_done_off", 64'(if_c.o_load_done), 64'd0);

    repeat (2) drv_a(1'b0, 1'b0);
    chk("sb_a_drained", 64'(q_a.size()), 64'd0);
    chk("sb_b_drained", 64'(q_b.size()), 64'd0);
    chk("sb_c_drained", 64'(q_c.size()), 64'd0);
    chk("frame_err_count", 64'(err_seen_a), 64'(err_exp_a));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
